can_reg_bank: RTL and testbench

- Register bank and message buffering directly downstream of the CAN user interface; consumes its IP2Can_* request bus and returns the Can2IP_* response.
- Holds mode, bit-timing and interrupt registers, a TX frame staging area with TX FIFO, and an RX FIFO fed by the CAN protocol core.
- Drives the protocol core through a valid/ready TX frame interface and accepts RX frames without backpressure.

---
 rtl/can_reg_bank.sv | 186 ++++++++++++++++++
 tb/tb_can_reg_bank.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_reg_bank.sv
// Register bank between the CAN user interface and the protocol core:
// mode/bit-timing/interrupt registers, TX staging with TX FIFO, and RX FIFO.
module can_reg_bank #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        IP2Can_reset,
  input  logic        IP2Can_CS,
  input  logic        IP2Can_RW,
  input  logic [7:0]  IP2Can_addr,
  input  logic [31:0] IP2Can_data,
  output logic [31:0] Can2IP_data,
  output logic        Can2IP_ack,
  output logic        Can2IP_interrupt,
  output logic        Can2IP_error,
  output logic        cfg_mode,
  output logic [15:0] btr,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [30:0] tx_id,
  output logic [3:0]  tx_dlc,
  output logic [63:0] tx_data,
  input  logic        tx_done,
  input  logic        bus_err,
  input  logic        rx_valid,
  input  logic [30:0] rx_id,
  input  logic [3:0]  rx_dlc,
  input  logic [63:0] rx_data
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
  localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

  localparam logic [7:0] A_MODE = 8'h00, A_BTR = 8'h04, A_IER = 8'h08, A_ISR = 8'h0C;
  localparam logic [7:0] A_STATUS = 8'h10, A_TX_ID = 8'h14, A_TX_DLC = 8'h18;
  localparam logic [7:0] A_TX_LO = 8'h1C, A_TX_HI = 8'h20, A_TX_CMD = 8'h24;
  localparam logic [7:0] A_RX_ID = 8'h28, A_RX_DLC = 8'h2C, A_RX_LO = 8'h30;
  localparam logic [7:0] A_RX_HI = 8'h34, A_RX_CMD = 8'h38;

  typedef enum logic {ST_IDLE, ST_DONE} state_t;

  typedef struct packed {
    logic [30:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

  state_t         state;
  logic [3:0]     ier;
  logic           isr_txd, isr_ovr, isr_berr;
  frame_t         stage;
  frame_t         tx_mem [TX_DEPTH];
  frame_t         rx_mem [RX_DEPTH];
  logic [TXW-1:0] tx_wr, tx_rd;
  logic [RXW-1:0] rx_wr, rx_rd;
  logic [TXW:0]   tx_cnt;
  logic [RXW:0]   rx_cnt;

  logic        acc, acc_err, wr_ok;
  logic [31:0] rd_val;
  logic [3:0]  isr, isr_clr;
  frame_t      tx_head, rx_vis;
  logic        rx_empty, rx_full, tx_pop, tx_push, rx_pop, rx_push;

  assign acc      = (state == ST_IDLE) && IP2Can_CS;
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_FULL);
  assign rx_vis   = rx_empty ? '0 : rx_mem[rx_rd];
  assign isr      = {isr_berr, isr_ovr, !rx_empty, isr_txd};
  assign tx_head  = tx_mem[tx_rd];
  assign tx_valid = (tx_cnt != '0);
  assign tx_id    = tx_head.id;
  assign tx_dlc   = tx_head.dlc;
  assign tx_data  = tx_head.data;
  assign tx_pop   = tx_valid && tx_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    acc_err = 1'b0;
    rd_val  = '0;
    case (IP2Can_addr)
      A_MODE:   rd_val = {31'b0, cfg_mode};
      A_BTR: begin
        rd_val  = {16'b0, btr};
        acc_err = !IP2Can_RW && !cfg_mode;
      end
      A_IER:    rd_val = {28'b0, ier};
      A_ISR:    rd_val = {28'b0, isr};
      A_STATUS: begin
        rd_val  = {16'b0, 8'(rx_cnt), 8'(tx_cnt)};
        acc_err = !IP2Can_RW;
      end
      A_TX_ID:  rd_val = {1'b0, stage.id};
      A_TX_DLC: rd_val = {28'b0, stage.dlc};
      A_TX_LO:  rd_val = stage.data[31:0];
      A_TX_HI:  rd_val = stage.data[63:32];
      // A push into a full FIFO is accepted only when the core drains an entry this cycle.
      A_TX_CMD: acc_err = IP2Can_RW || (IP2Can_data[0] && tx_cnt == TX_FULL && !tx_pop);
      A_RX_ID:  begin rd_val = {1'b0, rx_vis.id};   acc_err = !IP2Can_RW; end
      A_RX_DLC: begin rd_val = {28'b0, rx_vis.dlc}; acc_err = !IP2Can_RW; end
      A_RX_LO:  begin rd_val = rx_vis.data[31:0];   acc_err = !IP2Can_RW; end
      A_RX_HI:  begin rd_val = rx_vis.data[63:32];  acc_err = !IP2Can_RW; end
      A_RX_CMD: acc_err = IP2Can_RW || (IP2Can_data[0] && rx_empty);
      default:  acc_err = 1'b1;
    endcase
  end

  assign wr_ok   = acc && !IP2Can_RW && !acc_err;
  assign tx_push = wr_ok && (IP2Can_addr == A_TX_CMD) && IP2Can_data[0];
  assign rx_pop  = wr_ok && (IP2Can_addr == A_RX_CMD) && IP2Can_data[0];
  assign rx_push = rx_valid && (!rx_full || rx_pop);
  assign isr_clr = (wr_ok && IP2Can_addr == A_ISR) ? IP2Can_data[3:0] : 4'b0;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sys_clk or posedge IP2Can_reset) begin
    if (IP2Can_reset) begin
      state            <= ST_IDLE;
      Can2IP_data      <= '0;
      Can2IP_ack       <= 1'b0;
      Can2IP_error     <= 1'b0;
      Can2IP_interrupt <= 1'b0;
      cfg_mode         <= 1'b1;
      btr              <= '0;
      ier              <= '0;
      isr_txd          <= 1'b0;
      isr_ovr          <= 1'b0;
      isr_berr         <= 1'b0;
      stage            <= '0;
      tx_wr            <= '0;
      tx_rd            <= '0;
      tx_cnt           <= '0;
      rx_wr            <= '0;
      rx_rd            <= '0;
      rx_cnt           <= '0;
    end else begin
      case (state)
        ST_IDLE: if (IP2Can_CS) begin
          Can2IP_ack   <= 1'b1;
          Can2IP_error <= acc_err;
          Can2IP_data  <= (IP2Can_RW && !acc_err) ? rd_val : 32'b0;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          Can2IP_ack   <= 1'b0;
          Can2IP_error <= 1'b0;
          if (!IP2Can_CS) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (wr_ok) begin
        case (IP2Can_addr)
          A_MODE:   cfg_mode         <= IP2Can_data[0];
          A_BTR:    btr              <= IP2Can_data[15:0];
          A_IER:    ier              <= IP2Can_data[3:0];
          A_TX_ID:  stage.id         <= IP2Can_data[30:0];
          A_TX_DLC: stage.dlc        <= IP2Can_data[3:0];
          A_TX_LO:  stage.data[31:0] <= IP2Can_data;
          A_TX_HI:  stage.data[63:32] <= IP2Can_data;
          default: ;
        endcase
      end

      // Hardware events win over a same-cycle W1C clear.
      isr_txd  <= tx_done | (isr_txd & ~isr_clr[0]);
      isr_ovr  <= (rx_valid && rx_full && !rx_pop) | (isr_ovr & ~isr_clr[2]);
      isr_berr <= bus_err | (isr_berr & ~isr_clr[3]);
      Can2IP_interrupt <= |(isr & ier);

      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt + (TXW+1)'(tx_push) - (TXW+1)'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + (RXW+1)'(rx_push) - (RXW+1)'(rx_pop);
    end
  end

  // NOTE: FIFO storage is not reset; pointers and counts define what is valid.
  always_ff @(posedge sys_clk) begin
    if (tx_push) tx_mem[tx_wr] <= stage;
    if (rx_push) rx_mem[rx_wr] <= '{id: rx_id, dlc: rx_dlc, data: rx_data};
  end
endmodule

// File: tb/tb_can_reg_bank.sv
// Self-checking bench for can_reg_bank: directed steps plus random traffic
// compared against a queue-based reference model of the register bank.
module tb_can_reg_bank;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic        sys_clk = 1'b0;
  logic        IP2Can_reset, cs, rw;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] Can2IP_data;
  logic        Can2IP_ack, Can2IP_interrupt, Can2IP_error, cfg_mode;
  logic [15:0] btr;
  logic        tx_valid, tx_ready, tx_done, bus_err, rx_valid;
  logic [30:0] tx_id, rx_id;
  logic [3:0]  tx_dlc, rx_dlc;
  logic [63:0] tx_data, rx_data;

  can_reg_bank #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .sys_clk(sys_clk), .IP2Can_reset(IP2Can_reset), .IP2Can_CS(cs), .IP2Can_RW(rw),
    .IP2Can_addr(addr), .IP2Can_data(wdata), .Can2IP_data(Can2IP_data),
    .Can2IP_ack(Can2IP_ack), .Can2IP_interrupt(Can2IP_interrupt),
    .Can2IP_error(Can2IP_error), .cfg_mode(cfg_mode), .btr(btr),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id), .tx_dlc(tx_dlc),
    .tx_data(tx_data), .tx_done(tx_done), .bus_err(bus_err), .rx_valid(rx_valid),
    .rx_id(rx_id), .rx_dlc(rx_dlc), .rx_data(rx_data)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [30:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frm_t;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_mode, m_txd, m_ovr, m_berr, m_irq, m_err, rand_ev;
  logic [15:0] m_btr;
  logic [3:0]  m_ier;
  logic [31:0] m_rd;
  frm_t        m_stg;
  frm_t        tx_q[$];
  frm_t        rx_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_isr();
    return {m_berr, m_ovr, rx_q.size() != 0, m_txd};
  endfunction

  task automatic m_reset();
    m_mode = 1'b1; m_btr = '0; m_ier = '0; m_txd = 0; m_ovr = 0; m_berr = 0; m_irq = 0;
    m_stg = '{id: '0, dlc: '0, data: '0};
    tx_q.delete();
    rx_q.delete();
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then check.
  task automatic cycle(input bit acc);
    bit         tx_pop, tx_push, rx_pop, rx_full, irq_n;
    logic [3:0] clr, isr_pre;
    @(posedge sys_clk);
    tx_pop  = (tx_q.size() != 0) && tx_ready;
    rx_full = (rx_q.size() == RXD);
    isr_pre = m_isr();
    irq_n   = |(isr_pre & m_ier);
    tx_push = 0; rx_pop = 0; clr = '0;
    if (acc) begin
      m_err = 0; m_rd = '0;
      case (addr)
        8'h00: if (rw) m_rd = {31'b0, m_mode}; else m_mode = wdata[0];
        8'h04: if (rw) m_rd = {16'b0, m_btr}; else if (!m_mode) m_err = 1; else m_btr = wdata[15:0];
        8'h08: if (rw) m_rd = {28'b0, m_ier}; else m_ier = wdata[3:0];
        8'h0C: if (rw) m_rd = {28'b0, isr_pre}; else clr = wdata[3:0];
        8'h10: if (rw) m_rd = {16'b0, 8'(rx_q.size()), 8'(tx_q.size())}; else m_err = 1;
        8'h14: if (rw) m_rd = {1'b0, m_stg.id}; else m_stg.id = wdata[30:0];
        8'h18: if (rw) m_rd = {28'b0, m_stg.dlc}; else m_stg.dlc = wdata[3:0];
        8'h1C: if (rw) m_rd = m_stg.data[31:0]; else m_stg.data[31:0] = wdata;
        8'h20: if (rw) m_rd = m_stg.data[63:32]; else m_stg.data[63:32] = wdata;
        8'h24: if (rw) m_err = 1;
               else if (wdata[0]) begin
                 if (tx_q.size() == TXD && !tx_pop) m_err = 1; else tx_push = 1;
               end
        8'h28: if (!rw) m_err = 1; else if (rx_q.size() != 0) m_rd = {1'b0, rx_q[0].id};
        8'h2C: if (!rw) m_err = 1; else if (rx_q.size() != 0) m_rd = {28'b0, rx_q[0].dlc};
        8'h30: if (!rw) m_err = 1; else if (rx_q.size() != 0) m_rd = rx_q[0].data[31:0];
        8'h34: if (!rw) m_err = 1; else if (rx_q.size() != 0) m_rd = rx_q[0].data[63:32];
        8'h38: if (rw) m_err = 1;
               else if (wdata[0]) begin
                 if (rx_q.size() == 0) m_err = 1; else rx_pop = 1;
               end
        default: m_err = 1;
      endcase
      if (m_err) m_rd = '0;
    end
    m_txd  = tx_done | (m_txd & !clr[0]);
    m_ovr  = (rx_valid && rx_full && !rx_pop) | (m_ovr & !clr[2]);
    m_berr = bus_err | (m_berr & !clr[3]);
    if (tx_pop) void'(tx_q.pop_front());
    if (tx_push) tx_q.push_back(m_stg);
    if (rx_pop) void'(rx_q.pop_front());
    if (rx_valid && (!rx_full || rx_pop)) rx_q.push_back('{id: rx_id, dlc: rx_dlc, data: rx_data});
    m_irq = irq_n;
    #1;
    check("interrupt", Can2IP_interrupt, m_irq);
    check("tx_valid", tx_valid, tx_q.size() != 0);
    check("cfg_mode", cfg_mode, m_mode);
    check("btr", btr, m_btr);
    if (tx_q.size() != 0) check("tx_head", {tx_id, tx_dlc, tx_data}, {tx_q[0].id, tx_q[0].dlc, tx_q[0].data});
    if (rand_ev) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_id    = 31'($urandom);
      rx_dlc   = 4'($urandom);
      rx_data  = {$urandom, $urandom};
      tx_ready = ($urandom_range(0, 2) == 0);
      tx_done  = ($urandom_range(0, 7) == 0);
      bus_err  = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic access(input bit r, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] q, output logic e);
    cs = 1'b1; rw = r; addr = a; wdata = d;
    cycle(1);
    check($sformatf("ack_%02h", a), Can2IP_ack, 1'b1);
    check($sformatf("error_%02h", a), Can2IP_error, m_err);
    check($sformatf("data_%02h", a), Can2IP_data, m_rd);
    q = Can2IP_data;
    e = Can2IP_error;
    cycle(0);
    check("ack_drop", Can2IP_ack, 1'b0);
    check("error_drop", Can2IP_error, 1'b0);
    cs = 1'b0;
    cycle(0);
  endtask

  task automatic do_reset();
    IP2Can_reset = 1'b1;
    cs = 0; rw = 0; addr = '0; wdata = '0;
    tx_ready = 0; tx_done = 0; bus_err = 0; rx_valid = 0;
    rx_id = '0; rx_dlc = '0; rx_data = '0;
    repeat (2) @(posedge sys_clk);
    #1 IP2Can_reset = 1'b0;
    m_reset();
  endtask

  initial begin
    logic [31:0] q;
    logic        e;
    frm_t        f[5];
    int          n;
    int          acks;
    rand_ev = 0;

    // Reset state
    do_reset();
    check("rst_ack", Can2IP_ack, 1'b0);
    check("rst_error", Can2IP_error, 1'b0);
    check("rst_data", Can2IP_data, 32'h0);
    check("rst_irq", Can2IP_interrupt, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_mode", cfg_mode, 1'b1);
    access(1, 8'h00, 0, q, e);
    check("mode_rd", q, 32'h1);
    check("mode_rd_err", e, 1'b0);
    access(1, 8'h0C, 0, q, e);
    check("isr_rst", q, 32'h0);

    // BTR write protection outside configuration mode
    access(0, 8'h04, 32'h1234, q, e);
    check("btr_wr1_err", e, 1'b0);
    access(0, 8'h00, 32'h0, q, e);
    access(0, 8'h04, 32'hFFFF, q, e);
    check("btr_wr2_err", e, 1'b1);
    access(1, 8'h04, 0, q, e);
    check("btr_rb", q, 32'h1234);

    // TX staging and FIFO full
    tx_ready = 0;
    access(0, 8'h14, 32'h123, q, e);
    access(0, 8'h18, 32'h8, q, e);
    access(0, 8'h1C, 32'h04030201, q, e);
    access(0, 8'h20, 32'h08070605, q, e);
    for (int i = 0; i < 5; i++) begin
      access(0, 8'h24, 32'h1, q, e);
      check($sformatf("tx_cmd_err_%0d", i), e, i == 4);
    end
    check("tx_valid_full", tx_valid, 1'b1);
    check("tx_frame", {tx_id, tx_dlc, tx_data}, {31'h123, 4'h8, 64'h0807060504030201});
    access(1, 8'h10, 0, q, e);
    check("status_tx4", q, 32'h4);
    tx_ready = 1;
    n = 0;
    while (tx_valid && n < 10) begin
      cycle(0);
      n++;
    end
    check("tx_drain_cycles", n, 4);
    tx_ready = 0;

    // RX overrun and interrupt
    access(0, 8'h08, 32'h4, q, e);
    for (int i = 0; i < 5; i++) begin
      f[i] = '{id: 31'($urandom), dlc: 4'($urandom), data: {$urandom, $urandom}};
      rx_valid = 1; rx_id = f[i].id; rx_dlc = f[i].dlc; rx_data = f[i].data;
      cycle(0);
      rx_valid = 0;
    end
    access(1, 8'h10, 0, q, e);
    check("status_rx4", q, 32'h0400);
    access(1, 8'h0C, 0, q, e);
    check("isr_ovr", q, 32'h6);
    check("irq_set", Can2IP_interrupt, 1'b1);
    access(0, 8'h0C, 32'h4, q, e);
    access(1, 8'h0C, 0, q, e);
    check("isr_clr", q, 32'h2);
    check("irq_clr", Can2IP_interrupt, 1'b0);
    for (int i = 0; i < 4; i++) begin
      access(1, 8'h28, 0, q, e); check($sformatf("rx_id_%0d", i), q, {1'b0, f[i].id});
      access(1, 8'h2C, 0, q, e); check($sformatf("rx_dlc_%0d", i), q, {28'b0, f[i].dlc});
      access(1, 8'h30, 0, q, e); check($sformatf("rx_lo_%0d", i), q, f[i].data[31:0]);
      access(1, 8'h34, 0, q, e); check($sformatf("rx_hi_%0d", i), q, f[i].data[63:32]);
      access(0, 8'h38, 32'h1, q, e); check($sformatf("rx_pop_err_%0d", i), e, 1'b0);
    end
    access(0, 8'h38, 32'h1, q, e);
    check("rx_pop_empty_err", e, 1'b1);
    access(1, 8'h28, 0, q, e);
    check("rx_id_empty", q, 32'h0);

    // Long CS hold yields a single ack
    cs = 1; rw = 1; addr = 8'h00; wdata = 0;
    cycle(1);
    acks = int'(Can2IP_ack);
    for (int i = 0; i < 3; i++) begin
      cycle(0);
      acks += int'(Can2IP_ack);
    end
    cs = 0;
    cycle(0);
    acks += int'(Can2IP_ack);
    check("single_ack", acks, 1);
    access(1, 8'hFC, 0, q, e);
    check("unmapped_err", e, 1'b1);
    check("unmapped_data", q, 32'h0);

    // Random traffic against the model
    rand_ev = 1;
    for (int i = 0; i < 250; i++) begin
      logic [7:0]  a;
      logic [31:0] d;
      a = 8'(4 * $urandom_range(0, 15));
      d = $urandom;
      if ((a == 8'h24 || a == 8'h38) && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      access(($urandom_range(0, 1) == 1), a, d, q, e);
    end
    rand_ev = 0;
    rx_valid = 0; tx_ready = 0; tx_done = 0; bus_err = 0;
    cycle(0);

    // Reset while in DONE clears everything at once
    access(0, 8'h00, 32'h1, q, e);
    access(0, 8'h24, 32'h1, q, e);
    access(0, 8'h08, 32'hF, q, e);
    rx_valid = 1; rx_id = 31'h55; rx_dlc = 4'h1; rx_data = 64'h99;
    cycle(0);
    rx_valid = 0;
    cycle(0);
    check("pre_rst_irq", Can2IP_interrupt, 1'b1);
    cs = 1; rw = 1; addr = 8'h00; wdata = 0;
    cycle(1);
    check("pre_rst_ack", Can2IP_ack, 1'b1);
    #2 IP2Can_reset = 1'b1;
    cs = 0;
    #1;
    check("arst_ack", Can2IP_ack, 1'b0);
    check("arst_error", Can2IP_error, 1'b0);
    check("arst_data", Can2IP_data, 32'h0);
    check("arst_irq", Can2IP_interrupt, 1'b0);
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_mode", cfg_mode, 1'b1);
    @(posedge sys_clk);
    #1 IP2Can_reset = 1'b0;
    m_reset();
    cycle(0);
    access(1, 8'h10, 0, q, e);
    check("arst_status", q, 32'h0);
    access(1, 8'h0C, 0, q, e);
    check("arst_isr", q, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
